// File: rtl/mem_sched_pkg.sv
// Shared constants, width helpers and the round-robin pick function for the
// NPORTS-to-one memory scheduler.
package mem_sched_pkg;

  localparam int MEM_SCHED_AW = 16;
  localparam int MEM_SCHED_DW = 16;
  localparam int MAX_PORTS    = 16;

  typedef struct packed {
    logic       found;
    logic [3:0] idx;
  } rr_pick_t;

  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // First eligible index scanning last+1, last+2, ... modulo nports.
  function automatic rr_pick_t rr_pick(input logic [MAX_PORTS-1:0] eligible,
                                       input logic [3:0]           last,
                                       input int                   nports);
    rr_pick_t   res;
    int         j;
    logic [3:0] jj;
    res = '0;
    for (int k = 1; k <= MAX_PORTS; k++) begin
      j  = (int'(last) + k) % nports;
      jj = 4'(j);
      if (k <= nports && !res.found && eligible[jj]) begin
        res.found = 1'b1;
        res.idx   = jj;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/mem_sched_rr_arb.sv
// Round-robin arbiter: eligible vector in, one-hot grant out; owns last_gnt,
// which resets to NPORTS-1 so port 0 wins the first arbitration.
module mem_sched_rr_arb
  import mem_sched_pkg::*;
#(
  parameter int NPORTS = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NPORTS-1:0] eligible_i,
  output logic [NPORTS-1:0] gnt_o
);

  logic [3:0]           last_gnt_q;
  logic [3:0]           last_gnt_d;
  logic [MAX_PORTS-1:0] elig_ext;
  rr_pick_t             pick;

  // NOTE: every signal written here gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    elig_ext               = '0;
    elig_ext[NPORTS-1:0]   = eligible_i;
    pick                   = rr_pick(elig_ext, last_gnt_q, NPORTS);
    gnt_o                  = '0;
    for (int i = 0; i < NPORTS; i++) begin
      gnt_o[i] = pick.found && (pick.idx == 4'(i));
    end
    last_gnt_d = pick.found ? pick.idx : last_gnt_q;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (rst) last_gnt_q <= 4'(NPORTS - 1);
    else     last_gnt_q <= last_gnt_d;
  end

endmodule

// File: rtl/mem_sched_rr.sv
// Round-robin scheduler of NPORTS clients onto one in-order upstream memory port.
// Write forwarding is enabled by defining MEM_SCHED_WRITE_EN.
module mem_sched_rr
  import mem_sched_pkg::*;
#(
  parameter int NPORTS = 4,
  parameter int AW     = MEM_SCHED_AW,
  parameter int DW     = MEM_SCHED_DW,
  parameter int DEPTH  = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NPORTS-1:0]          port_req,
  input  logic [NPORTS*AW-1:0]       port_addr,
  input  logic [NPORTS-1:0]          port_we,
  input  logic [NPORTS*DW-1:0]       port_wdata,
  output logic [NPORTS-1:0]          port_gnt,
  output logic [NPORTS-1:0]          port_rvalid,
  output logic [DW-1:0]              port_rdata,
  input  logic                       up_busy,
  output logic                       up_req,
  output logic                       up_we,
  output logic [AW-1:0]              up_addr,
  output logic [DW-1:0]              up_wdata,
  input  logic                       up_rvalid,
  input  logic [DW-1:0]              up_rdata,
  output logic [$clog2(DEPTH+1)-1:0] outstanding,
  output logic                       resp_err
);

  localparam int CW = cnt_w(DEPTH);
  localparam int PW = ptr_w(DEPTH);
  localparam int OW = idx_w(NPORTS);

  logic [OW-1:0]     owner_mem [DEPTH];
  logic [PW-1:0]     head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]     count_q, count_d;
  logic              up_req_q, up_req_d, up_we_q, up_we_d;
  logic [AW-1:0]     up_addr_q, up_addr_d;
  logic [DW-1:0]     up_wdata_q, up_wdata_d;
  logic [NPORTS-1:0] port_rvalid_q, port_rvalid_d;
  logic [DW-1:0]     port_rdata_q, port_rdata_d;
  logic              resp_err_q, resp_err_d;

  logic [NPORTS-1:0]    is_write, eligible, gnt;
  logic [NPORTS*DW-1:0] wdata_in;
  logic                 fifo_full, fifo_empty, gnt_any, gnt_is_write, push, pop;
  logic [OW-1:0]        gnt_idx;
  logic [AW-1:0]        sel_addr;
  logic [DW-1:0]        sel_wdata;

`ifdef MEM_SCHED_WRITE_EN
  assign is_write = port_we;
  assign wdata_in = port_wdata;
`else
  // Without write support every request is a read and the write inputs are inert.
  logic unused_write_ports;
  assign unused_write_ports = ^{port_we, port_wdata};
  assign is_write = '0;
  assign wdata_in = '0;
`endif

  assign fifo_full  = (count_q == CW'(DEPTH));
  assign fifo_empty = (count_q == '0);

  always_comb begin
    for (int i = 0; i < NPORTS; i++) begin
      eligible[i] = !rst && port_req[i] && !up_busy && (is_write[i] || !fifo_full);
    end
  end

  mem_sched_rr_arb #(.NPORTS(NPORTS)) u_arb (
    .clk        (clk),
    .rst        (rst),
    .eligible_i (eligible),
    .gnt_o      (gnt)
  );

  always_comb begin
    gnt_idx      = '0;
    sel_addr     = '0;
    sel_wdata    = '0;
    gnt_is_write = 1'b0;
    for (int i = 0; i < NPORTS; i++) begin
      if (gnt[i]) begin
        gnt_idx      = OW'(i);
        sel_addr     = port_addr[i*AW +: AW];
        sel_wdata    = wdata_in[i*DW +: DW];
        gnt_is_write = is_write[i];
      end
    end
  end

  assign gnt_any = |gnt;
  assign push    = gnt_any && !gnt_is_write;
  assign pop     = up_rvalid && !fifo_empty;

  always_comb begin
    head_d        = head_q;
    tail_d        = tail_q;
    count_d       = count_q;
    up_req_d      = gnt_any;
    up_we_d       = up_we_q;
    up_addr_d     = up_addr_q;
    up_wdata_d    = up_wdata_q;
    port_rvalid_d = '0;
    port_rdata_d  = port_rdata_q;
    // A response with nothing outstanding is dropped and latched as an error.
    resp_err_d    = resp_err_q | (up_rvalid && fifo_empty);

    if (gnt_any) begin
      up_we_d    = gnt_is_write;
      up_addr_d  = sel_addr;
      up_wdata_d = sel_wdata;
    end
    if (push) head_d = head_q + PW'(1);
    if (pop) begin
      tail_d       = tail_q + PW'(1);
      port_rdata_d = up_rdata;
      for (int i = 0; i < NPORTS; i++) begin
        port_rvalid_d[i] = (owner_mem[tail_q] == OW'(i));
      end
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q        <= '0;
      tail_q        <= '0;
      count_q       <= '0;
      up_req_q      <= 1'b0;
      up_we_q       <= 1'b0;
      up_addr_q     <= '0;
      up_wdata_q    <= '0;
      port_rvalid_q <= '0;
      port_rdata_q  <= '0;
      resp_err_q    <= 1'b0;
    end else begin
      head_q        <= head_d;
      tail_q        <= tail_d;
      count_q       <= count_d;
      up_req_q      <= up_req_d;
      up_we_q       <= up_we_d;
      up_addr_q     <= up_addr_d;
      up_wdata_q    <= up_wdata_d;
      port_rvalid_q <= port_rvalid_d;
      port_rdata_q  <= port_rdata_d;
      resp_err_q    <= resp_err_d;
    end
  end

  // NOTE: the owner storage has no reset; an entry is only read after being
  // written, since count gates every pop.
  always_ff @(posedge clk) begin
    if (push) owner_mem[head_q] <= gnt_idx;
  end

  assign port_gnt    = gnt;
  assign port_rvalid = port_rvalid_q;
  assign port_rdata  = port_rdata_q;
  assign up_req      = up_req_q;
  assign up_we       = up_we_q;
  assign up_addr     = up_addr_q;
  assign up_wdata    = up_wdata_q;
  assign outstanding = count_q;
  assign resp_err    = resp_err_q;

endmodule

// File: tb/tb_mem_sched_rr.sv
// Self-checking bench for mem_sched_rr: directed scenarios plus random traffic
// compared each cycle against a queue-based round-robin reference model.
module tb_mem_sched_rr;

  localparam int NP    = 4;
  localparam int AW    = 16;
  localparam int DW    = 16;
  localparam int DEPTH = 8;

  logic                       clk = 1'b0;
  logic                       rst;
  logic [NP-1:0]              port_req, port_we, port_gnt, port_rvalid;
  logic [NP*AW-1:0]           port_addr;
  logic [NP*DW-1:0]           port_wdata;
  logic [DW-1:0]              port_rdata, up_wdata, up_rdata;
  logic                       up_busy, up_req, up_we, up_rvalid, resp_err;
  logic [AW-1:0]              up_addr;
  logic [$clog2(DEPTH+1)-1:0] outstanding;

  mem_sched_rr #(.NPORTS(NP), .AW(AW), .DW(DW), .DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .port_req    (port_req),
    .port_addr   (port_addr),
    .port_we     (port_we),
    .port_wdata  (port_wdata),
    .port_gnt    (port_gnt),
    .port_rvalid (port_rvalid),
    .port_rdata  (port_rdata),
    .up_busy     (up_busy),
    .up_req      (up_req),
    .up_we       (up_we),
    .up_addr     (up_addr),
    .up_wdata    (up_wdata),
    .up_rvalid   (up_rvalid),
    .up_rdata    (up_rdata),
    .outstanding (outstanding),
    .resp_err    (resp_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model: outstanding reads as an ordered queue of (owner, address).
  typedef struct { int owner; logic [AW-1:0] addr; } rd_t;
  typedef struct { logic [AW-1:0] addr; int ready_cyc; } up_t;

  rd_t           m_q[$];
  up_t           upq[$];
  int            m_last;
  logic          m_err;
  logic          exp_up_req, exp_up_we;
  logic [AW-1:0] exp_up_addr;
  logic [DW-1:0] exp_up_wdata, exp_rdata;
  logic [NP-1:0] exp_rvalid;
  int            cyc = 0;
  int            g_log[$];
  logic [NP-1:0] g_obs;
  int            obs_rv[NP];

  logic [AW-1:0] addr_a[NP];
  logic [DW-1:0] wdata_a[NP];
  logic [NP-1:0] we_v;

  function automatic logic [DW-1:0] tag(input logic [AW-1:0] a);
    return a ^ 16'hC3C3;
  endfunction

  function automatic logic we_eff(input int p);
`ifdef MEM_SCHED_WRITE_EN
    return we_v[p];
`else
    return 1'b0;
`endif
  endfunction

  task automatic pack_inputs();
    for (int i = 0; i < NP; i++) begin
      port_addr[i*AW +: AW]  = addr_a[i];
      port_wdata[i*DW +: DW] = wdata_a[i];
    end
    port_we = we_v;
  endtask

  task automatic model_reset();
    m_q.delete();
    upq.delete();
    m_last       = NP - 1;
    m_err        = 1'b0;
    exp_up_req   = 1'b0;
    exp_up_we    = 1'b0;
    exp_up_addr  = '0;
    exp_up_wdata = '0;
    exp_rdata    = '0;
    exp_rvalid   = '0;
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    port_req  = '1;
    up_busy   = 1'b0;
    up_rvalid = 1'b0;
    up_rdata  = '0;
    #1;
    check("gnt_during_rst", port_gnt, '0);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst      = 1'b0;
    port_req = '0;
    model_reset();
    check("rst_up_req", up_req, 1'b0);
    check("rst_up_addr", up_addr, '0);
    check("rst_up_we", up_we, 1'b0);
    check("rst_up_wdata", up_wdata, '0);
    check("rst_outstanding", outstanding, '0);
    check("rst_port_rvalid", port_rvalid, '0);
    check("rst_port_rdata", port_rdata, '0);
    check("rst_resp_err", resp_err, 1'b0);
  endtask

  // One clock cycle. up_mode 0: rv/rd forced; 1: upstream answers as soon as a
  // read is 2 cycles old; 2: same, but only with 50% probability.
  task automatic step(input logic [NP-1:0] req, input logic busy, input int up_mode,
                      input logic rv_force, input logic [DW-1:0] rd_force);
    logic          rv;
    logic [DW-1:0] rd;
    int            win, j;
    logic [NP-1:0] exp_g;
    rd_t           r;
    rv = rv_force;
    rd = rd_force;
    if (up_mode != 0) begin
      rv = 1'b0;
      rd = '0;
      if (upq.size() > 0 && upq[0].ready_cyc <= cyc &&
          (up_mode == 1 || $urandom_range(1, 0) == 1)) begin
        rv = 1'b1;
        rd = tag(upq[0].addr);
        void'(upq.pop_front());
      end
    end
    pack_inputs();
    port_req  = req;
    up_busy   = busy;
    up_rvalid = rv;
    up_rdata  = rd;
    #1;
    win = -1;
    for (int k = 1; k <= NP; k++) begin
      j = (m_last + k) % NP;
      if (win < 0 && req[j] && !busy && (we_eff(j) || m_q.size() < DEPTH)) win = j;
    end
    exp_g = (win >= 0) ? (NP'(1) << win) : '0;
    g_obs = port_gnt;
    check("port_gnt", port_gnt, exp_g);
    if (win >= 0) g_log.push_back(win);

    exp_rvalid = '0;
    if (rv) begin
      if (m_q.size() > 0) begin
        r          = m_q.pop_front();
        exp_rvalid = NP'(1) << r.owner;
        exp_rdata  = rd;
      end else begin
        m_err = 1'b1;
      end
    end
    if (win >= 0) begin
      exp_up_req  = 1'b1;
      exp_up_addr = addr_a[win];
`ifdef MEM_SCHED_WRITE_EN
      exp_up_we    = we_v[win];
      exp_up_wdata = wdata_a[win];
`endif
      if (!we_eff(win)) begin
        m_q.push_back('{win, addr_a[win]});
        upq.push_back('{addr_a[win], cyc + 2});
      end
      m_last = win;
    end else begin
      exp_up_req = 1'b0;
    end

    @(posedge clk);
    #1;
    cyc++;
    check("up_req", up_req, exp_up_req);
    check("up_addr", up_addr, exp_up_addr);
    check("up_we", up_we, exp_up_we);
    check("up_wdata", up_wdata, exp_up_wdata);
    check("outstanding", outstanding, m_q.size());
    check("port_rvalid", port_rvalid, exp_rvalid);
    check("port_rdata", port_rdata, exp_rdata);
    check("resp_err", resp_err, m_err);
    for (int p = 0; p < NP; p++) if (port_rvalid[p]) obs_rv[p]++;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    we_v = '0;
    for (int i = 0; i < NP; i++) begin
      addr_a[i]  = '0;
      wdata_a[i] = '0;
      obs_rv[i]  = 0;
    end
    pack_inputs();
    model_reset();

    // Single read at 0x1234 on port 0, answered with 0xBEEF.
    do_reset();
    addr_a[0] = 16'h1234;
    step(4'b0001, 1'b0, 0, 1'b0, '0);
    check("t1_gnt", g_obs, 4'b0001);
    check("t1_up_req", up_req, 1'b1);
    check("t1_up_addr", up_addr, 16'h1234);
    check("t1_outstanding", outstanding, 1);
    step(4'b0000, 1'b0, 0, 1'b1, 16'hBEEF);
    check("t1_rvalid", port_rvalid, 4'b0001);
    check("t1_rdata", port_rdata, 16'hBEEF);

    // All ports request continuously; upstream answers each read 2 cycles later.
    do_reset();
    for (int i = 0; i < NP; i++) addr_a[i] = 16'h0A00 + 16'(i * 16'h0111);
    g_log.delete();
    for (int i = 0; i < NP; i++) obs_rv[i] = 0;
    for (int n = 0; n < 24; n++) step('1, 1'b0, 1, 1'b0, '0);
    for (int n = 0; n < 4; n++) step('0, 1'b0, 1, 1'b0, '0);
    check("rr_grant_count", g_log.size(), 24);
    for (int i = 0; i < 24 && i < g_log.size(); i++) check("rr_order", g_log[i], i % NP);
    for (int p = 0; p < NP; p++) check("rr_resp_per_port", obs_rv[p], 6);

    // Port 2 fills the owner FIFO with no responses.
    do_reset();
    addr_a[2] = 16'h2200;
    g_log.delete();
    for (int n = 0; n < 10; n++) step(4'b0100, 1'b0, 0, 1'b0, '0);
    check("full_grants", g_log.size(), DEPTH);
    check("full_gnt_zero", g_obs, 4'b0000);
    check("full_outstanding", outstanding, DEPTH);
    step(4'b0100, 1'b0, 0, 1'b1, 16'h7777);
    check("full_pop_cycle_gnt", g_obs, 4'b0000);
    check("full_pop_rvalid", port_rvalid, 4'b0100);
    step(4'b0100, 1'b0, 0, 1'b0, '0);
    check("full_regrant", g_obs, 4'b0100);
    check("full_outstanding2", outstanding, DEPTH);

`ifdef MEM_SCHED_WRITE_EN
    // Write on port 1 while the FIFO is full.
    addr_a[1]  = 16'h0040;
    wdata_a[1] = 16'h5A5A;
    we_v       = 4'b0010;
    step(4'b0010, 1'b0, 0, 1'b0, '0);
    check("wr_gnt", g_obs, 4'b0010);
    check("wr_up_we", up_we, 1'b1);
    check("wr_up_wdata", up_wdata, 16'h5A5A);
    check("wr_up_addr", up_addr, 16'h0040);
    check("wr_outstanding", outstanding, DEPTH);
    check("wr_no_rvalid", port_rvalid, '0);
    we_v = '0;
`endif

    // Upstream busy for 5 cycles while ports 1 and 3 request.
    do_reset();
    addr_a[1] = 16'h1100;
    addr_a[3] = 16'h3300;
    for (int n = 0; n < 5; n++) begin
      step(4'b1010, 1'b1, 0, 1'b0, '0);
      check("busy_no_gnt", g_obs, 4'b0000);
      check("busy_no_up_req", up_req, 1'b0);
    end
    step(4'b1010, 1'b0, 0, 1'b0, '0);
    check("busy_rel_first", g_obs, 4'b0010);
    step(4'b1010, 1'b0, 0, 1'b0, '0);
    check("busy_rel_second", g_obs, 4'b1000);

    // Response with nothing outstanding.
    do_reset();
    step(4'b0000, 1'b0, 0, 1'b1, 16'hDEAD);
    check("uf_resp_err", resp_err, 1'b1);
    check("uf_rvalid", port_rvalid, '0);
    check("uf_outstanding", outstanding, 0);
    for (int n = 0; n < 3; n++) step(4'b0000, 1'b0, 0, 1'b0, '0);
    check("uf_sticky", resp_err, 1'b1);
    do_reset();

    // Random traffic with random upstream latency, including a mid-run reset.
    for (int n = 0; n < 400; n++) begin
      if (n == 200) do_reset();
      for (int i = 0; i < NP; i++) begin
        addr_a[i]  = 16'($urandom);
        wdata_a[i] = 16'($urandom);
      end
`ifdef MEM_SCHED_WRITE_EN
      we_v = NP'($urandom);
`endif
      step(NP'($urandom), ($urandom_range(3, 0) == 0), 2, 1'b0, '0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_sched_rr.md
Name: mem_sched_rr

Overview:
- Parametrised round-robin memory scheduler that arbitrates NPORTS client ports onto one upstream memory port. It is the successor to the fixed 4-port, 16-bit scheduler.
- Generalised in port count, address/data width and outstanding-read depth. Adds an explicit grant handshake, an outstanding-read counter, response-underflow error detection and optional write support.
- Sits between the video fetch clients (scanline, sprite, CPU) and the memory controller.

Parameters:
- NPORTS, 4, number of client ports; legal range 2..16.
- AW, 16, address width.
- DW, 16, data width.
- DEPTH, 8, maximum outstanding reads; sets owner-FIFO depth; power of 2, at least 2.

Ports:
- clk  in  1  single clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- port_req  in  NPORTS  per-port request; held high until granted.
- port_addr  in  NPORTS*AW  per-port address; port i at bits [i*AW +: AW].
- port_we  in  NPORTS  per-port write flag (MEM_SCHED_WRITE_EN only).
- port_wdata  in  NPORTS*DW  per-port write data (MEM_SCHED_WRITE_EN only).
- port_gnt  out  NPORTS  one-hot, combinational accept pulse.
- port_rvalid  out  NPORTS  one-hot, registered read-response strobe.
- port_rdata  out  DW  registered read data, shared by all ports.
- up_busy  in  1  upstream cannot accept a request this cycle.
- up_req  out  1  registered upstream request strobe.
- up_we  out  1  registered upstream write flag.
- up_addr  out  AW  registered upstream address.
- up_wdata  out  DW  registered upstream write data.
- up_rvalid  in  1  upstream read data valid; in-order, one per read.
- up_rdata  in  DW  upstream read data.
- outstanding  out  $clog2(DEPTH+1)  reads issued but not yet answered.
- resp_err  out  1  sticky flag: up_rvalid arrived with no outstanding read.

Behaviour:
- Reset (rst high at a posedge) forces:
  - port_rvalid=0, port_rdata=0, up_req=0, up_we=0, up_addr=0, up_wdata=0;
  - outstanding=0, resp_err=0;
  - FIFO head/tail=0;
  - last_gnt=NPORTS-1, so port 0 wins first.
  - port_gnt is 0 while rst is high.
- Request handshake:
  - A client raises port_req[i] with address (and write data) stable.
  - The transfer completes in the cycle port_gnt[i]=1.
  - The client may drop or change the request in the following cycle.
  - Back-to-back requests are allowed; there is no per-port outstanding limit.
- Eligibility, computed each cycle:
  - A port is eligible if port_req[i]=1 and up_busy=0.
  - A read additionally needs FIFO count < DEPTH. Count does not account for a same-cycle pop; full stays full.
  - A write (feature on) needs only up_busy=0.
- Arbitration:
  - The grant goes to the first eligible port scanning last_gnt+1, last_gnt+2, ..., wrapping modulo NPORTS.
  - At most one grant per cycle.
  - last_gnt updates only on a grant.
  - An ineligible requester (a read blocked by a full FIFO) is skipped; it does not block others.
- Issue, at the posedge ending the grant cycle:
  - up_req<=1; up_addr, up_we and up_wdata are loaded from the granted port.
  - For a read, the owner index is pushed to the FIFO.
  - With no grant, up_req<=0 and the other up_* outputs hold.
  - Latency: grant in cycle t, up_req high in cycle t+1.
- Response:
  - When up_rvalid=1 and the FIFO is non-empty, the tail is popped.
  - port_rvalid[owner]<=1 and port_rdata<=up_rdata, visible in cycle t+1 (one-cycle latency).
  - Otherwise port_rvalid<=0 and port_rdata holds.
- Underflow: up_rvalid=1 with the FIFO empty sets resp_err, drops the data and changes no pointer. resp_err clears only on reset.
- Simultaneous push and pop: both take effect; outstanding is unchanged.
- Counter: outstanding equals FIFO count, ranging 0..DEPTH. Pointers wrap modulo DEPTH.
- Reset mid-operation: all in-flight reads are discarded. The upstream must be reset together with this block, otherwise its late responses set resp_err.

Optional Feature:
- Macro: MEM_SCHED_WRITE_EN.
- Defined:
  - port_we[i]=1 requests are writes; they are forwarded with up_we=1.
  - Writes push no FIFO entry, produce no port_rvalid and are grantable while the FIFO is full.
  - Writes and reads share one round-robin order.
- Undefined:
  - port_we and port_wdata are ignored; every request is a read.
  - up_we stays 0 and up_wdata stays 0.

Decomposition:
- Package mem_sched_pkg:
  - default constants MEM_SCHED_AW=16, MEM_SCHED_DW=16;
  - function rr_pick(eligible, last) returning the winning index, plus a found bit;
  - function clog2-based width helpers.
- Sub-module mem_sched_rr_arb (NPORTS): eligible vector in, one-hot grant out, owns the last_gnt register.
- The owner FIFO stays inline.

Test Plan:
- Reset, then port 0 requests a read at 0x1234 with up_busy=0.
  - Required: port_gnt=0001 in the same cycle; next cycle up_req=1, up_addr=0x1234, outstanding=1.
  - Then up_rvalid with 0xBEEF gives port_rvalid[0]=1 and port_rdata=0xBEEF one cycle later.
- All 4 ports request continuously (reads) while upstream answers each read 2 cycles later.
  - Required: grant order 0,1,2,3,0,1,... with no repeats.
  - Each port receives its own address tag as data, in order.
- DEPTH=8 with no responses and port 2 requesting reads continuously.
  - Required: exactly 8 grants, then port_gnt=0 and outstanding=8.
  - One up_rvalid yields one further grant the cycle after the pop.
- up_busy held high for 5 cycles while ports 1 and 3 request.
  - Required: no grants and up_req=0.
  - After release: port 1 granted, then port 3.
- up_rvalid pulsed with outstanding=0.
  - Required: resp_err=1 the next cycle, port_rvalid=0, outstanding stays 0; cleared only by rst.
- With MEM_SCHED_WRITE_EN, FIFO full, port 1 write to 0x0040 with data 0x5A5A.
  - Required: granted, up_we=1, up_wdata=0x5A5A, outstanding stays 8, no port_rvalid.
